// File: rtl/operand_mux_stage.sv
`default_nettype none
// ============================================================================
//  Module   : operand_mux_stage
//  Purpose  : Selects one of NUM_IN packed input words and passes it through
//             a two-entry (main + skid) elastic stage with valid/ready
//             handshakes on both sides. Selectors beyond the last input fall
//             back to the last input and raise a sticky error flag.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             in_data         - NUM_IN packed words, word k at [k*WIDTH +: WIDTH]
//             in_sel          - index of the word to capture
//             in_valid/ready  - upstream handshake (in_ready is registered)
//             flush           - drop every held word and any offered word
//             out_data/valid  - head of the stage
//             out_ready       - downstream accepts out_data
//             sel_err         - sticky: an out-of-range selector was accepted
//  Revision : 1.0 - initial release
// ============================================================================
module operand_mux_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    localparam int unsigned c_LAST_IDX = NUM_IN - 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_main_data;
    logic [WIDTH-1:0]   r_skid_data;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_sel_err;

    logic [WIDTH-1:0]   w_sel_word;
    logic               w_sel_oob;
    logic               w_xfer_in;
    logic               w_xfer_out;

    // Out-of-range selectors resolve to the last input. When NUM_IN equals
    // 2**SEL_W the comparison can never be true, so sel_err stays clear.
    assign w_sel_oob = (32'(in_sel) >= NUM_IN);

    always_comb begin
        w_sel_word = in_data[c_LAST_IDX*WIDTH +: WIDTH];
        for (int unsigned k = 0; k < c_LAST_IDX; k++) begin
            if (32'(in_sel) == k) begin
                w_sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer_in  = in_valid & r_in_ready;
    assign w_xfer_out = r_out_valid & out_ready;

    // Single state machine; out_valid and in_ready are registered alongside
    // the state so in_ready never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_sel_err   <= 1'b0;
        end else if (flush) begin
            // Flush beats any same-cycle transfer; sel_err keeps its value
            // and is not updated by the dropped offer.
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            if (w_xfer_in && w_sel_oob) begin
                r_sel_err <= 1'b1;
            end
            case (r_state)
                S_EMPTY: begin
                    if (w_xfer_in) begin
                        r_main_data <= w_sel_word;
                        r_state     <= S_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_xfer_in && w_xfer_out) begin
                        // Head drains while the new word lands behind it.
                        r_main_data <= w_sel_word;
                    end else if (w_xfer_in) begin
                        r_skid_data <= w_sel_word;
                        r_state     <= S_FULL;
                        r_in_ready  <= 1'b0;
                    end else if (w_xfer_out) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (w_xfer_out) begin
                        r_main_data <= r_skid_data;
                        r_state     <= S_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_data  = r_main_data;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_operand_mux_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_mux_stage
//  Purpose  : Self-checking bench for operand_mux_stage. A queue-based model
//             (capacity two) predicts out_valid/out_data/in_ready/sel_err and
//             is compared every cycle; directed scenarios pin the model with
//             literal expectations, followed by a long randomized run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_mux_stage;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 3;
    localparam int unsigned SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;

    int total = 0;
    int bad   = 0;

    operand_mux_stage #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an ordered queue holding at most two words.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mq[$];
    bit               m_err    = 1'b0;
    bit               m_ready  = 1'b1;
    bit               chk_en   = 1'b0;
    bit               hold_exp = 1'b0;   // head must stay put this cycle
    logic [WIDTH-1:0] hold_word;

    always @(posedge clk) begin
        int unsigned      idx;
        logic [WIDTH-1:0] word;
        bit               acc_in;
        bit               acc_out;
        hold_exp = 1'b0;
        if (rst) begin
            mq.delete();
            m_err   = 1'b0;
            chk_en  = 1'b1;
        end else if (chk_en) begin
            acc_in  = in_valid && (mq.size() < 2);
            acc_out = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && !out_ready) begin
                    hold_exp  = 1'b1;
                    hold_word = mq[0];
                end
                idx  = (32'(in_sel) < NUM_IN) ? 32'(in_sel) : NUM_IN - 1;
                word = in_data[idx*WIDTH +: WIDTH];
                if (acc_out) void'(mq.pop_front());
                if (acc_in) begin
                    mq.push_back(word);
                    if (32'(in_sel) >= NUM_IN) m_err = 1'b1;
                end
            end
        end
        m_ready = (mq.size() < 2);
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("in_ready",  64'(in_ready),  64'(m_ready));
            check("sel_err",   64'(sel_err),   64'(m_err));
            if (mq.size() > 0) check("out_data", 64'(out_data), 64'(mq[0]));
            if (hold_exp)      check("out_data_stable", 64'(out_data), 64'(hold_word));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_words(input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w1,
                             input logic [WIDTH-1:0] w0);
        in_data = {w2, w1, w0};
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = '0;
        out_ready = 1'b0; in_data = '0;
        tick(); tick();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_sel_err",   64'(sel_err),   64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // Single word, sel=1 -> B after one cycle
        set_words(32'hC, 32'hB, 32'hA);
        in_valid = 1'b1; in_sel = 2'd1; out_ready = 1'b1;
        tick();
        check("lat1_valid", 64'(out_valid), 64'd1);
        check("lat1_data",  64'(out_data),  64'hB);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);

        // Fill to FULL under backpressure, then drain in order
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
        tick();
        in_sel = 2'd2;
        tick();
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready),  64'd0);
        check("full_head",     64'(out_data),  64'hA);
        tick();
        check("full_hold",     64'(out_data),  64'hA);
        out_ready = 1'b1;
        tick();
        check("drain_second",  64'(out_data),  64'hC);
        check("drain_second_v",64'(out_valid), 64'd1);
        tick();
        check("drain_empty",   64'(out_valid), 64'd0);

        // Out-of-range selector: falls back to input 2, flag sticky past flush
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd3;
        tick();
        check("oob_data",    64'(out_data), 64'hC);
        check("oob_err",     64'(sel_err),  64'd1);
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("err_after_flush",   64'(sel_err),   64'd1);
        check("valid_after_flush", 64'(out_valid), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_after_rst", 64'(sel_err), 64'd0);

        // Flush in FULL with an offered word
        in_valid = 1'b1; in_sel = 2'd0;
        tick();
        in_sel = 2'd1;
        tick();
        set_words(32'hDEAD, 32'hDEAD, 32'hDEAD);
        flush = 1'b1; in_sel = 2'd2;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        tick();
        check("flush_dropped", 64'(out_valid), 64'd0);

        // Reset while FULL with a pending offer and sel_err set
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd3;
        tick();
        tick();
        check("pre_rst_err", 64'(sel_err), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_full_valid", 64'(out_valid), 64'd0);
        check("rst_full_ready", 64'(in_ready),  64'd1);
        check("rst_full_err",   64'(sel_err),   64'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < int'(NUM_IN); k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            in_sel    = SEL_W'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 99) < 65);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) == 0);
            rst       = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
